fdam_req_arbiter_2to1: RTL and testbench

- Two-input round-robin request arbiter with per-input FIFOs. Merges memory request streams (address/mdata, plus payload for writes) from two accelerator ports into one request stream.
- Sits directly upstream of the accelerator-management output registers. Its output drives their req_rd_en/req_wr_en and data capture.
- Instances can be cascaded into arbiter trees. Output available is fed from the host-side request-available signal.

---
 rtl/fdam_req_arbiter_2to1.sv | 123 ++++++++++++
 tb/tb_fdam_req_arbiter_2to1.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fdam_req_arbiter_2to1.sv
// fdam_req_arbiter_2to1: two-input round-robin request arbiter with per-input FIFOs.
// Optional statistics counters are enabled by defining FDAM_ARB_STATS_EN.
module fdam_req_arbiter_2to1 #(
    parameter int DATA_WIDTH            = 576,
    parameter int INPUT_FIFO_DEPTH_BITS = 5,
    parameter int AVAIL_MARGIN          = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                req_wr_en_in,
    input  logic [2*DATA_WIDTH-1:0]   req_wr_data_in,
    output logic [1:0]                req_wr_available_in,
    input  logic                      req_wr_available_out,
    output logic                      req_wr_en_out,
    output logic [DATA_WIDTH-1:0]     req_wr_data_out
`ifdef FDAM_ARB_STATS_EN
    ,
    output logic [31:0]               grant_cnt_0,
    output logic [31:0]               grant_cnt_1,
    output logic [15:0]               drop_cnt
`endif
);
    localparam int DB    = INPUT_FIFO_DEPTH_BITS;
    localparam int DEPTH = 1 << DB;

    logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];
    logic [DB:0]           cnt_q [2];
    logic [DB:0]           cnt_d [2];
    logic [DB-1:0]         wp_q  [2];
    logic [DB-1:0]         wp_d  [2];
    logic [DB-1:0]         rp_q  [2];
    logic [DB-1:0]         rp_d  [2];
    logic                  rr_q, rr_d;
    logic                  en_q, en_d;
    logic [1:0]            avail_q, avail_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            ne, push, pop;
    logic                  gnt;

    // Grant selection, FIFO pointer/count updates and registered output word.
    always_comb begin
        ne[0]  = cnt_q[0] != '0;
        ne[1]  = cnt_q[1] != '0;
        gnt    = (ne[0] && ne[1]) ? ~rr_q : ne[1];
        pop[0] = req_wr_available_out && |ne && !gnt;
        pop[1] = req_wr_available_out && |ne && gnt;
        rr_d   = |pop ? gnt : rr_q;
        en_d   = |pop;
        data_d = |pop ? mem_q[gnt][rp_q[gnt]] : data_q;
        for (int i = 0; i < 2; i++) begin
            // the top count bit is set only when full; a same-cycle pop frees a slot
            push[i]    = req_wr_en_in[i] && (!cnt_q[i][DB] || pop[i]);
            cnt_d[i]   = cnt_q[i] + {{DB{1'b0}}, push[i]} - {{DB{1'b0}}, pop[i]};
            wp_d[i]    = wp_q[i] + {{(DB-1){1'b0}}, push[i]};
            rp_d[i]    = rp_q[i] + {{(DB-1){1'b0}}, pop[i]};
            avail_d[i] = int'(cnt_d[i]) < DEPTH - AVAIL_MARGIN;
        end
    end

    // State registers; reset discards all queued requests and the in-flight output.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= 1'b0;
            en_q    <= 1'b0;
            avail_q <= 2'b00;
            data_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
                wp_q[i]  <= '0;
                rp_q[i]  <= '0;
            end
        end else begin
            rr_q    <= rr_d;
            en_q    <= en_d;
            avail_q <= avail_d;
            data_q  <= data_d;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
                wp_q[i]  <= wp_d[i];
                rp_q[i]  <= rp_d[i];
            end
        end
    end

    // FIFO storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (push[i]) mem_q[i][wp_q[i]] <= req_wr_data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign req_wr_en_out       = en_q;
    assign req_wr_data_out     = data_q;
    assign req_wr_available_in = avail_q;

`ifdef FDAM_ARB_STATS_EN
    logic [31:0] gc0_q, gc0_d, gc1_q, gc1_d;
    logic [15:0] drop_q, drop_d;

    // Wrapping grant and drop counters.
    always_comb begin
        gc0_d  = gc0_q + 32'(pop[0]);
        gc1_d  = gc1_q + 32'(pop[1]);
        drop_d = drop_q + 16'(req_wr_en_in[0] && !push[0]) + 16'(req_wr_en_in[1] && !push[1]);
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            gc0_q  <= '0;
            gc1_q  <= '0;
            drop_q <= '0;
        end else begin
            gc0_q  <= gc0_d;
            gc1_q  <= gc1_d;
            drop_q <= drop_d;
        end
    end

    assign grant_cnt_0 = gc0_q;
    assign grant_cnt_1 = gc1_q;
    assign drop_cnt    = drop_q;
`endif
endmodule

// File: tb/tb_fdam_req_arbiter_2to1.sv
// tb_fdam_req_arbiter_2to1: randomized scoreboard bench for fdam_req_arbiter_2to1.
module tb_fdam_req_arbiter_2to1;
    localparam int DW = 576;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    wr_en = 2'b00;
    logic [2*DW-1:0] wr_data = '0;
    logic [1:0]    avail_in;
    logic          avail_out = 1'b0;
    logic          en_out;
    logic [DW-1:0] data_out;
`ifdef FDAM_ARB_STATS_EN
    logic [31:0]   gc0, gc1;
    logic [15:0]   dc;
`endif

    fdam_req_arbiter_2to1 dut (
        .clk(clk),
        .rst(rst),
        .req_wr_en_in(wr_en),
        .req_wr_data_in(wr_data),
        .req_wr_available_in(avail_in),
        .req_wr_available_out(avail_out),
        .req_wr_en_out(en_out),
        .req_wr_data_out(data_out)
`ifdef FDAM_ARB_STATS_EN
        ,
        .grant_cnt_0(gc0),
        .grant_cnt_1(gc1),
        .drop_cnt(dc)
`endif
    );

    always #5 clk = ~clk;

    // reference model state: per-input queues, last winner, expected outputs
    logic [DW-1:0] q0[$], q1[$], sb[$];
    int            rr = 0;
    bit            started = 0;
    logic          exp_en = 0;
    logic [DW-1:0] exp_data = '0;
    logic [1:0]    exp_av = 2'b00;
    int            m_g0 = 0, m_g1 = 0, m_drop = 0;
    int            n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Behavioural model evaluated at every rising edge from the sampled inputs.
    always @(posedge clk) begin
        int g;
        bit f0, f1;
        logic [DW-1:0] w;
        started = 1;
        if (rst) begin
            q0.delete(); q1.delete(); sb.delete();
            rr = 0; exp_en = 0; exp_data = '0; exp_av = 2'b00;
            m_g0 = 0; m_g1 = 0; m_drop = 0;
        end else begin
            g = -1;
            f0 = q0.size() == 32;
            f1 = q1.size() == 32;
            if (avail_out) begin
                if (q0.size() > 0 && q1.size() > 0) g = (rr == 0) ? 1 : 0;
                else if (q0.size() > 0) g = 0;
                else if (q1.size() > 0) g = 1;
            end
            exp_en = g >= 0;
            if (g == 0) begin w = q0.pop_front(); m_g0++; end
            if (g == 1) begin w = q1.pop_front(); m_g1++; end
            if (g >= 0) begin rr = g; exp_data = w; sb.push_back(w); end
            if (wr_en[0]) begin
                if (!f0 || g == 0) q0.push_back(wr_data[0 +: DW]); else m_drop++;
            end
            if (wr_en[1]) begin
                if (!f1 || g == 1) q1.push_back(wr_data[DW +: DW]); else m_drop++;
            end
            exp_av[0] = 32 - q0.size() > 4;
            exp_av[1] = 32 - q1.size() > 4;
        end
    end

    // Monitor: compares DUT outputs against the model on the falling edge.
    always @(negedge clk) begin
        logic [DW-1:0] w;
        if (started) begin
            chk("en_out", DW'(en_out), DW'(exp_en));
            if (en_out === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_word at %0t: got %h expected none", $time, data_out);
                end else begin
                    w = sb.pop_front();
                    chk("word", data_out, w);
                end
            end
            chk("data_hold", data_out, exp_data);
            chk("avail_in", DW'(avail_in), DW'(exp_av));
`ifdef FDAM_ARB_STATS_EN
            chk("grant_cnt_0", DW'(gc0), DW'(m_g0));
            chk("grant_cnt_1", DW'(gc1), DW'(m_g1));
            chk("drop_cnt", DW'(dc), DW'(m_drop));
`endif
        end
    end

    task automatic drive(input logic [1:0] en, input logic av);
        @(negedge clk);
        wr_en = en;
        avail_out = av;
        for (int k = 0; k < 2*DW/32; k++) wr_data[k*32 +: 32] = $urandom;
    endtask

    initial begin
        repeat (2) drive(2'b00, 1'b1);
        rst = 1'b0;
        drive(2'b00, 1'b1);
        // single input stream
        repeat (3) drive(2'b01, 1'b1);
        repeat (4) drive(2'b00, 1'b1);
        // fairness: preload both, then release
        repeat (4) drive(2'b11, 1'b0);
        repeat (10) drive(2'b00, 1'b1);
        // backpressure in the middle of a stream
        repeat (5) drive(2'b01, 1'b1);
        repeat (10) drive(2'b01, 1'b0);
        repeat (5) drive(2'b01, 1'b1);
        repeat (25) drive(2'b00, 1'b1);
        // fill input 1 past full
        repeat (33) drive(2'b10, 1'b0);
        repeat (40) drive(2'b00, 1'b1);
        // full input 0, then push while popping
        repeat (32) drive(2'b01, 1'b0);
        drive(2'b01, 1'b1);
        repeat (40) drive(2'b00, 1'b1);
        // reset with both FIFOs half full
        repeat (16) drive(2'b11, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (3) drive(2'b00, 1'b1);
        // random traffic
        for (int c = 0; c < 3000; c++)
            drive(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
        repeat (80) drive(2'b00, 1'b1);
        n_chk++;
        if (sb.size() == 0 && q0.size() == 0 && q1.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size() + q0.size() + q1.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
